// File: rtl/stb_mon.sv
// Strobe monitor: synchronises an asynchronous strobe, measures the period and high time
// of each cycle in clk_i cycles, checks the period against a tolerance and flags a lost strobe.
module stb_mon #(
  parameter int T_CNT_WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TOL         = 2,
  parameter int N_CNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic                   stb_i,
  input  logic                   en_i,
  input  logic [T_CNT_WIDTH-1:0] exp_period_i,
  input  logic [T_CNT_WIDTH-1:0] timeout_i,
  output logic                   rdy_o,
  output logic                   valid_o,
  output logic [T_CNT_WIDTH-1:0] period_o,
  output logic [T_CNT_WIDTH-1:0] width_o,
  output logic [N_CNT_WIDTH-1:0] pulse_cnt_o,
  output logic                   err_o,
  output logic                   lost_o
);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_RISE, MEASURE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   synced;
  logic                   rise;
  logic                   fall;
  logic [T_CNT_WIDTH-1:0] cnt;
  logic [T_CNT_WIDTH-1:0] width_lat;
  logic                   timeout_hit;

  // Absolute period error in one extra bit so the subtraction never wraps.
  function automatic logic out_of_tol(input logic [T_CNT_WIDTH-1:0] meas,
                                      input logic [T_CNT_WIDTH-1:0] expv);
    logic [T_CNT_WIDTH:0] a;
    logic [T_CNT_WIDTH:0] b;
    logic [T_CNT_WIDTH:0] diff;
    a    = {1'b0, meas};
    b    = {1'b0, expv};
    diff = (a >= b) ? (a - b) : (b - a);
    return diff > (T_CNT_WIDTH+1)'(TOL);
  endfunction

  assign synced      = sync_q[SYNC_STAGES-1];
  assign rise        = synced & ~prev_q;
  assign fall        = ~synced & prev_q;
  assign timeout_hit = (timeout_i != '0) && (cnt == timeout_i) && !rise;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], stb_i};
      prev_q <= synced;
    end
  end

  // Free-running cycle counter, restarted by every rise and held at all-ones.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= T_CNT_WIDTH'(1);
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state       <= IDLE;
      rdy_o       <= 1'b1;
      valid_o     <= 1'b0;
      period_o    <= '0;
      width_o     <= '0;
      width_lat   <= '0;
      pulse_cnt_o <= '0;
      err_o       <= 1'b0;
      lost_o      <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (!en_i) begin
        state <= IDLE;
        rdy_o <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state       <= WAIT_LOW;
            rdy_o       <= 1'b0;
            err_o       <= 1'b0;
            lost_o      <= 1'b0;
            pulse_cnt_o <= '0;
          end
          WAIT_LOW: begin
            if (!synced) state <= WAIT_RISE;
          end
          WAIT_RISE: begin
            if (rise) begin
              state <= MEASURE;
            end else if (timeout_hit) begin
              lost_o <= 1'b1;
              state  <= WAIT_LOW;
            end
          end
          MEASURE: begin
            // A fall coinciding with a timeout still records the high time.
            if (fall) width_lat <= cnt;
            if (rise) begin
              period_o <= cnt;
              width_o  <= width_lat;
              valid_o  <= 1'b1;
              if (pulse_cnt_o != '1) pulse_cnt_o <= pulse_cnt_o + 1'b1;
              if (out_of_tol(cnt, exp_period_i)) err_o <= 1'b1;
            end else if (timeout_hit) begin
              lost_o <= 1'b1;
              state  <= WAIT_LOW;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stb_mon.sv
// Bench for stb_mon: directed strobe patterns, a cycle-indexed reference model checked
// every cycle, and hand-computed expectations for the key measurements.
module tb_stb_mon;

  localparam int TW          = 32;
  localparam int NW          = 16;
  localparam int SYNC_STAGES = 2;
  localparam int TOL         = 2;
  localparam longint TMAX    = 64'h0000_0000_FFFF_FFFF;
  localparam int PH_LOW  = 0;
  localparam int PH_RISE = 1;
  localparam int PH_MEAS = 2;

  logic          clk = 1'b0;
  logic          arst_ni = 1'b0;
  logic          stb_i = 1'b0;
  logic          en_i = 1'b0;
  logic [TW-1:0] exp_period_i = 32'd100;
  logic [TW-1:0] timeout_i = 32'd0;
  logic          rdy_o;
  logic          valid_o;
  logic [TW-1:0] period_o;
  logic [TW-1:0] width_o;
  logic [NW-1:0] pulse_cnt_o;
  logic          err_o;
  logic          lost_o;

  int n_cmp = 0;
  int n_bad = 0;

  stb_mon #(.T_CNT_WIDTH(TW), .SYNC_STAGES(SYNC_STAGES), .TOL(TOL), .N_CNT_WIDTH(NW)) dut (
    .clk_i(clk), .arst_ni(arst_ni), .stb_i(stb_i), .en_i(en_i),
    .exp_period_i(exp_period_i), .timeout_i(timeout_i),
    .rdy_o(rdy_o), .valid_o(valid_o), .period_o(period_o), .width_o(width_o),
    .pulse_cnt_o(pulse_cnt_o), .err_o(err_o), .lost_o(lost_o)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Strobe generator: gen_left pulses of gen_period/gen_high, optional one-off stretched period.
  int gen_left = 0;
  int gen_period = 20;
  int gen_high = 10;
  int stretch = 0;
  logic gen_level = 1'b0;
  int rise_edge = 0;

  initial begin
    int p;
    forever begin
      @(posedge clk);
      #2;
      if (gen_left > 0) begin
        p = gen_period;
        if (stretch != 0) begin
          p = stretch;
          stretch = 0;
        end
        stb_i = 1'b1;
        rise_edge = edge_cnt;
        repeat (gen_high) @(posedge clk);
        #2 stb_i = 1'b0;
        repeat (p - gen_high - 1) @(posedge clk);
        gen_left--;
      end else begin
        stb_i = gen_level;
      end
    end
  end

  // Reference model: the synchronised strobe is the input sample SYNC_STAGES edges back,
  // and every count is the distance in edges from the last rise.
  bit samp [0:65535];
  int n = 0;
  longint last_rise = 1;
  bit m_on = 0;
  int m_phase = PH_LOW;
  longint wl = 0;
  logic          e_valid = 0;
  logic          e_rdy = 1;
  logic [TW-1:0] e_period = 0;
  logic [TW-1:0] e_width = 0;
  logic [NW-1:0] e_pcnt = 0;
  logic          e_err = 0;
  logic          e_lost = 0;

  function automatic bit sget(input int i);
    return (i < 1) ? 1'b0 : samp[i];
  endfunction

  always @(posedge clk or negedge arst_ni) begin
    bit syn, prv, rise, fall, tmo;
    longint c, d;
    if (!arst_ni) begin
      n = 0; last_rise = 1; m_on = 0; m_phase = PH_LOW; wl = 0;
      e_valid = 0; e_rdy = 1; e_period = 0; e_width = 0; e_pcnt = 0; e_err = 0; e_lost = 0;
    end else begin
      n++;
      samp[n] = stb_i;
      syn  = sget(n - SYNC_STAGES);
      prv  = sget(n - SYNC_STAGES - 1);
      rise = syn && !prv;
      fall = !syn && prv;
      c = n - last_rise;
      if (c > TMAX) c = TMAX;
      tmo = (timeout_i != 0) && (c == longint'(timeout_i)) && !rise;
      e_valid = 0;
      if (!en_i) begin
        m_on = 0;
      end else if (!m_on) begin
        m_on = 1; m_phase = PH_LOW; e_err = 0; e_lost = 0; e_pcnt = 0;
      end else if (m_phase == PH_LOW) begin
        if (!syn) m_phase = PH_RISE;
      end else begin
        if (m_phase == PH_MEAS && fall) wl = c;
        if (rise) begin
          if (m_phase == PH_MEAS) begin
            e_period = c[TW-1:0];
            e_width  = wl[TW-1:0];
            e_valid  = 1;
            if (e_pcnt != 16'hFFFF) e_pcnt = e_pcnt + 1'b1;
            d = c - longint'(exp_period_i);
            if (d < 0) d = -d;
            if (d > TOL) e_err = 1;
          end
          m_phase = PH_MEAS;
        end else if (tmo) begin
          e_lost = 1; m_phase = PH_LOW;
        end
      end
      e_rdy = !m_on;
      if (rise) last_rise = n;
    end
  end

  always @(negedge clk) begin
    chk("m_valid", valid_o, e_valid);
    chk("m_rdy", rdy_o, e_rdy);
    chk("m_period", period_o, e_period);
    chk("m_width", width_o, e_width);
    chk("m_pulse_cnt", pulse_cnt_o, e_pcnt);
    chk("m_err", err_o, e_err);
    chk("m_lost", lost_o, e_lost);
  end

  task automatic wait_valid(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    chk({nm, "_valid_seen"}, seen, 1);
  endtask

  initial begin
    int delay;
    bit seen;

    // 1: reset held, strobe toggling, then released with the monitor disabled
    gen_period = 20; gen_high = 10; gen_left = 2;
    repeat (50) @(negedge clk);
    chk("rst_rdy", rdy_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_pulse_cnt", pulse_cnt_o, 0);
    chk("rst_period", period_o, 0);
    arst_ni = 1'b1;
    gen_left += 2;
    repeat (50) @(negedge clk);
    chk("dis_rdy", rdy_o, 1);
    chk("dis_pulse_cnt", pulse_cnt_o, 0);

    // 2: nominal 100/30 strobe
    gen_period = 100; gen_high = 30;
    en_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("en_rdy", rdy_o, 0);
    gen_left += 5;
    wait_valid("nom1");
    chk("nom1_period", period_o, 100);
    chk("nom1_width", width_o, 30);
    chk("nom1_err", err_o, 0);
    chk("nom1_pulse_cnt", pulse_cnt_o, 1);
    wait_valid("nom2");
    chk("nom2_pulse_cnt", pulse_cnt_o, 2);
    wait_valid("nom3");
    wait_valid("nom4");
    chk("nom4_pulse_cnt", pulse_cnt_o, 4);

    // 3: one period stretched to 105, err sticky until re-enable
    gen_left += 3; stretch = 105;
    wait_valid("str1");
    chk("str1_period", period_o, 100);
    chk("str1_err", err_o, 0);
    wait_valid("str2");
    chk("str2_period", period_o, 105);
    chk("str2_err", err_o, 1);
    wait_valid("str3");
    chk("str3_period", period_o, 100);
    chk("str3_err_sticky", err_o, 1);
    en_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("off_rdy", rdy_o, 1);
    chk("off_err_hold", err_o, 1);
    chk("off_pulse_cnt_hold", pulse_cnt_o, 7);
    en_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("reen_err", err_o, 0);
    chk("reen_pulse_cnt", pulse_cnt_o, 0);
    chk("reen_period_hold", period_o, 100);

    // 4: timeout after the strobe stops low
    timeout_i = 32'd500;
    gen_left += 4;
    wait_valid("to1");
    wait_valid("to2");
    wait_valid("to3");
    chk("to_pulse_cnt", pulse_cnt_o, 3);
    seen = 0; delay = 0;
    for (int i = 0; i < 700 && !seen; i++) begin
      @(negedge clk);
      if (lost_o) begin
        seen = 1;
        delay = edge_cnt - rise_edge;
      end
    end
    chk("lost_seen", seen, 1);
    chk("lost_delay", delay, 500 + SYNC_STAGES + 1);
    chk("lost_pulse_cnt", pulse_cnt_o, 3);

    // 5: enable while the strobe is high
    timeout_i = 32'd0;
    en_i = 1'b0;
    gen_level = 1'b1;
    repeat (10) @(negedge clk);
    en_i = 1'b1;
    repeat (30) @(negedge clk);
    chk("hi_pulse_cnt", pulse_cnt_o, 0);
    chk("hi_lost", lost_o, 0);
    gen_level = 1'b0;
    repeat (37) @(negedge clk);
    gen_left += 3;
    wait_valid("hi1");
    chk("hi1_period", period_o, 100);
    chk("hi1_width", width_o, 30);
    chk("hi1_pulse_cnt", pulse_cnt_o, 1);

    // 6: asynchronous reset mid-period with en_i held high
    gen_left += 3;
    repeat (40) @(negedge clk);
    #3 arst_ni = 1'b0;
    #1;
    chk("arst_async_rdy", rdy_o, 1);
    chk("arst_async_period", period_o, 0);
    @(negedge clk);
    chk("arst_valid", valid_o, 0);
    chk("arst_width", width_o, 0);
    chk("arst_pulse_cnt", pulse_cnt_o, 0);
    repeat (2) @(negedge clk);
    arst_ni = 1'b1;
    wait_valid("rs1");
    chk("rs1_period", period_o, 100);
    chk("rs1_width", width_o, 30);
    chk("rs1_pulse_cnt", pulse_cnt_o, 1);
    repeat (200) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stb_mon.md
Name: stb_mon

Overview:
- Strobe monitor: the receiving end of the strobe interface driven by the measure unit's strobe generator.
- Samples an asynchronous strobe and measures the period and high time of every strobe cycle, in clk_i cycles.
- Compares each measured period against an expected period within a tolerance, counts received pulses, and flags a missing strobe with a timeout.
- Used in the measure unit for loopback self-check and calibration of the strobe path.

Parameters:
T_CNT_WIDTH, 32, width of all cycle counters and period/width values
SYNC_STAGES, 2, synchroniser depth on stb_i (minimum 2)
TOL, 2, allowed absolute period error in clk cycles
N_CNT_WIDTH, 16, width of the received-pulse counter

Ports:
clk_i  in  1  system clock
arst_ni  in  1  asynchronous active-low reset
stb_i  in  1  strobe under test, asynchronous to clk_i
en_i  in  1  monitor enable, level
exp_period_i  in  T_CNT_WIDTH  expected strobe period in clk cycles, static while en_i=1
timeout_i  in  T_CNT_WIDTH  cycles without a rising edge before lost_o sets; 0 disables the timeout
rdy_o  out  1  high in IDLE
valid_o  out  1  one-cycle pulse when period_o/width_o update
period_o  out  T_CNT_WIDTH  last measured period
width_o  out  T_CNT_WIDTH  last measured high time
pulse_cnt_o  out  N_CNT_WIDTH  completed periods since start, saturating
err_o  out  1  sticky: a period fell outside exp_period_i±TOL
lost_o  out  1  sticky: timeout expired

Behaviour:
- Reset (arst_ni low, asynchronous):
  - state=IDLE; synchroniser, edge registers and cnt cleared.
  - All outputs 0 except rdy_o=1.
- Input path:
  - stb_i passes through a SYNC_STAGES flop chain, then a previous-value register.
  - rise = synced & ~prev; fall = ~synced & prev.
  - Latency from a stb_i edge to its rise/fall pulse is SYNC_STAGES+1 cycles.
- Counter cnt:
  - On a rise cycle, cnt<=1; otherwise cnt<=cnt+1, saturating at all-ones.
  - Rise pulses P cycles apart therefore leave cnt=P on the second rise.
- States: IDLE, WAIT_LOW, WAIT_RISE, MEASURE.
  - IDLE: when en_i=1, go to WAIT_LOW and clear err_o, lost_o, pulse_cnt_o. Clearing happens only on this transition.
  - WAIT_LOW: when synced=0, go to WAIT_RISE. This guarantees the first captured edge is a genuine rise.
  - WAIT_RISE: on rise, go to MEASURE (cnt restarts at 1).
  - MEASURE, on fall: width_lat<=cnt.
  - MEASURE, on rise, the next cycle:
    - period_o<=cnt and width_o<=width_lat;
    - valid_o=1;
    - pulse_cnt_o increments, saturating;
    - err_o sets if |cnt−exp_period_i|>TOL.
    - Compare in T_CNT_WIDTH+1 bits; no wrap on subtraction.
    - State stays MEASURE.
- Timeout: in WAIT_RISE or MEASURE, with timeout_i≠0 and cnt==timeout_i and no rise in that cycle:
  - lost_o<=1;
  - state goes to WAIT_LOW;
  - no valid_o is issued for the partial period.
  - In WAIT_RISE, cnt keeps counting from its last value, so the first timeout can fire early. This is acceptable.
- en_i=0 in any state: go to IDLE on the next cycle. period_o, width_o, pulse_cnt_o, err_o and lost_o hold their values.
- Simultaneous fall and timeout: the fall still latches width_lat; the timeout takes priority for the state change.
- Saturated period: if cnt saturates, period_o reports all-ones and err_o sets unless exp_period_i is within TOL of all-ones.
- Strobe pulses shorter than one clk cycle may be missed. This is a documented limitation, not an error.
- Mid-operation reset: returns everything to reset values immediately, with no pending valid_o.

Test Plan:
1. Reset low, en_i=0 → rdy_o=1, valid_o=0, all counters 0; toggling stb_i changes nothing.
2. en_i=1, exp_period_i=100, TOL=2, stb_i period 100 clk with high time 30 clk → first valid_o about 1 period after the first rise; period_o=100, width_o=30, err_o=0; pulse_cnt_o increments by 1 per period.
3. Same setup, one period stretched to 105 → on that valid_o, period_o=105 and err_o=1; err_o stays 1 after periods return to 100, until en_i toggles 0→1.
4. timeout_i=500, stb_i stops low after 3 periods → lost_o=1 exactly 500 cycles after the last rise pulse; state returns to WAIT_LOW; pulse_cnt_o=3 (the first rise only starts measurement, so three complete periods give pulse_cnt_o=3).
5. en_i asserted while stb_i is high → no measurement until after a fall followed by a rise; the first period_o equals the true period.
6. arst_ni pulsed low mid-period → outputs clear asynchronously; with en_i held high, the monitor restarts in IDLE→WAIT_LOW and the next measured period_o is correct.
